// File: rtl/bictr_dcnto_mode.sv
// bictr_dcnto_mode: parametrised up/down binary counter with a dynamic
// count-to compare and four terminal-count modes (FREE, STOP, RELOAD, BOUNCE).
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   load      synchronous load of data (beats cen)
//   data      load value; also the reload value in RELOAD mode
//   cen       count enable
//   up_dn     1=up, 0=down (in BOUNCE only sampled at load)
//   step      increment magnitude, 0 = hold
//   count_to  dynamic terminal value
//   mode      00 FREE, 01 STOP, 10 RELOAD, 11 BOUNCE
//   clr_flag  synchronous clear of tc_sticky (a same-cycle set wins)
//   count     registered count
//   tercnt    combinational count == count_to
//   tc_pulse  1-cycle pulse after a count step lands on count_to
//   tc_sticky sticky version of tc_pulse
//   carry     1-cycle pulse when a step wrapped past max (up) or 0 (down)
//   dir       registered effective direction (1=up)
//   halted    STOP mode is holding at the terminal value
module bictr_dcnto_mode #(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic              cen,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  count_to,
    input  logic [1:0]        mode,
    input  logic              clr_flag,
    output logic [WIDTH-1:0]  count,
    output logic              tercnt,
    output logic              tc_pulse,
    output logic              tc_sticky,
    output logic              carry,
    output logic              dir,
    output logic              halted
);

    typedef enum logic [1:0] {
        MODE_FREE   = 2'b00,
        MODE_STOP   = 2'b01,
        MODE_RELOAD = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    mode_e mode_s;
    assign mode_s = mode_e'(mode);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             halted_q, halted_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic             tc_sticky_q, tc_sticky_d;
    logic             carry_q, carry_d;

    // All arithmetic is done one bit wider so the top bit carries the
    // overflow (up) or the borrow (down) of a single step.
    logic [WIDTH:0] step_x, cnt_x, cto_x, sum_up, sum_dn;
    logic           borrow, up_cross, dn_cross, do_step, eff_dir, reload_hit;

    assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign cnt_x  = {1'b0, count_q};
    assign cto_x  = {1'b0, count_to};
    assign sum_up = cnt_x + step_x;
    assign sum_dn = cnt_x - step_x;
    assign borrow = sum_dn[WIDTH];

    // A step reaches or crosses count_to, using the unwrapped step result:
    // a downward step that underflows still counts as crossing count_to.
    assign up_cross = (cnt_x < cto_x) && (cto_x <= sum_up);
    assign dn_cross = (cto_x < cnt_x) && ((cnt_x - cto_x) <= step_x);

    assign do_step = cen && (step != '0) && !halted_q;
    assign eff_dir = (mode_s == MODE_BOUNCE) ? dir_q : up_dn;

    always_comb begin
        count_d     = count_q;
        dir_d       = dir_q;
        halted_d    = halted_q;
        tc_pulse_d  = 1'b0;
        carry_d     = 1'b0;
        reload_hit  = 1'b0;
        tc_sticky_d = clr_flag ? 1'b0 : tc_sticky_q;

        if (load) begin
            count_d  = data;
            dir_d    = up_dn;
            halted_d = 1'b0;
        end else if (do_step) begin
            // Start from the free-running result, then let the mode override it.
            dir_d   = eff_dir;
            count_d = eff_dir ? sum_up[WIDTH-1:0] : sum_dn[WIDTH-1:0];
            carry_d = eff_dir ? sum_up[WIDTH] : borrow;
            case (mode_s)
                MODE_FREE: begin
                end
                MODE_STOP: begin
                    if (eff_dir ? up_cross : dn_cross) begin
                        count_d  = count_to;
                        carry_d  = 1'b0;
                        halted_d = 1'b1;
                    end
                end
                MODE_RELOAD: begin
                    if (count_q == count_to) begin
                        count_d    = data;
                        carry_d    = 1'b0;
                        reload_hit = 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // count_to is the ceiling and 0 the floor; hitting either
                    // clamps and reverses, so the counter never wraps here.
                    carry_d = 1'b0;
                    if (eff_dir) begin
                        if (sum_up >= cto_x) begin
                            count_d = count_to;
                            dir_d   = 1'b0;
                        end
                    end else if (step_x >= cnt_x) begin
                        count_d = '0;
                        dir_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (!reload_hit && (count_d == count_to)) begin
                tc_pulse_d  = 1'b1;
                tc_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= RESET_VAL;
            dir_q       <= 1'b1;
            halted_q    <= 1'b0;
            tc_pulse_q  <= 1'b0;
            tc_sticky_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            dir_q       <= dir_d;
            halted_q    <= halted_d;
            tc_pulse_q  <= tc_pulse_d;
            tc_sticky_q <= tc_sticky_d;
            carry_q     <= carry_d;
        end
    end

    assign count     = count_q;
    assign tercnt    = (count_q == count_to);
    assign tc_pulse  = tc_pulse_q;
    assign tc_sticky = tc_sticky_q;
    assign carry     = carry_q;
    assign dir       = dir_q;
    assign halted    = halted_q;

endmodule
